// File: rtl/req_slice.sv
// Registered request/response slice between the priority merge and one slave.
// One transaction in flight; optional watchdog aborts a stalled slave access.
module req_slice #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TIMEOUT = 0,
  parameter logic [DATA_W-1:0] TIMEOUT_RDATA = DATA_W'(32'hDEADBEEF),
  localparam int unsigned STRB_W = DATA_W / 8,
  localparam int unsigned REQ_W = 1 + ADDR_W + DATA_W + STRB_W,
  localparam int unsigned RESP_W = DATA_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REQ_W-1:0]  m_req,
  output logic [RESP_W-1:0] m_resp,
  output logic [REQ_W-1:0]  s_req,
  input  logic [RESP_W-1:0] s_resp,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e state_q, state_d;

  logic              m_valid;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [STRB_W-1:0] m_wstrb;
  logic              s_ready;
  logic [DATA_W-1:0] s_rdata;

  assign {m_valid, m_addr, m_wdata, m_wstrb} = m_req;
  assign {s_rdata, s_ready} = s_resp;

  logic              s_valid_q, s_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      s_valid_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      s_valid_q <= s_valid_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Response flops default to zero so m_resp is nonzero only during the RESP cycle.
  always_comb begin
    state_d   = state_q;
    s_valid_d = s_valid_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = '0;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (m_valid) begin
          addr_d    = m_addr;
          wdata_d   = m_wdata;
          wstrb_d   = m_wstrb;
          s_valid_d = 1'b1;
          cnt_d     = '0;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (s_ready) begin
          rdata_d   = s_rdata;
          ready_d   = 1'b1;
          s_valid_d = 1'b0;
          state_d   = StResp;
        end else if (timeout_hit) begin
          rdata_d   = TIMEOUT_RDATA;
          ready_d   = 1'b1;
          err_d     = 1'b1;
          s_valid_d = 1'b0;
          state_d   = StResp;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d   = StIdle;
        s_valid_d = 1'b0;
      end
    endcase
  end

  assign s_req       = {s_valid_q, addr_q, wdata_q, wstrb_q};
  assign m_resp      = {rdata_q, ready_q};
  assign busy        = (state_q != StIdle);
  assign timeout_err = err_q;

endmodule

// File: tb/tb_req_slice.sv
// Self-checking bench for req_slice: directed scenarios plus randomized transactions
// checked against a per-transaction outcome model.
module tb_req_slice;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TO     = 8;
  localparam int unsigned REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
  localparam int unsigned RESP_W = DATA_W + 1;
  localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [REQ_W-1:0]  m_req;
  logic [RESP_W-1:0] m_resp;
  logic [REQ_W-1:0]  s_req;
  logic [RESP_W-1:0] s_resp;
  logic              busy;
  logic              timeout_err;

  int total = 0;
  int bad   = 0;

  req_slice #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m_req      (m_req),
    .m_resp     (m_resp),
    .s_req      (s_req),
    .s_resp     (s_resp),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outcome of one transaction: slave answering on WAIT cycle lat (if it answers at all)
  // wins up to and including the TO-th cycle; otherwise the watchdog aborts at TO.
  function automatic void ref_txn(input int lat, input bit resp, input logic [31:0] sdata,
                                  output int waitc, output logic [31:0] rd, output bit err);
    if (resp && lat <= int'(TO)) begin
      waitc = lat;
      rd    = sdata;
      err   = 1'b0;
    end else begin
      waitc = TO;
      rd    = ABORT_DATA;
      err   = 1'b1;
    end
  endfunction

  // Starts just after a clock edge with the DUT idle; ends after one idle cycle.
  task automatic run_txn(input string name, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] st, input int lat, input bit resp,
                         input logic [31:0] sdata);
    int waitc, cyc, svc, busyc, errc, ready_at, wseen;
    logic [31:0] exp_rd, got_rd;
    bit exp_err;
    logic got_err;
    logic [REQ_W-1:0] exp_sreq;
    ref_txn(lat, resp, sdata, waitc, exp_rd, exp_err);
    exp_sreq = {1'b1, a, d, st};
    m_req = exp_sreq;
    cyc = 0; svc = 0; busyc = 0; errc = 0; ready_at = -1; wseen = 0;
    got_rd = '0; got_err = 1'b0;
    while (ready_at < 0 && cyc < 40) begin
      step();
      cyc++;
      if (s_req[REQ_W-1]) begin
        svc++;
        wseen++;
        chk({name, "_sreq"}, 128'(s_req), 128'(exp_sreq));
      end
      if (busy) busyc++;
      if (timeout_err) errc++;
      if (m_resp[0]) begin
        ready_at = cyc;
        got_rd   = m_resp[32:1];
        got_err  = timeout_err;
        m_req    = {1'b0, 32'($urandom), 32'($urandom), 4'($urandom)};
      end else begin
        // Valid held; payload churn must not reach the latched slave request.
        m_req = {1'b1, 32'($urandom), 32'($urandom), 4'($urandom)};
      end
      s_resp = {(wseen == lat && s_req[REQ_W-1]) ? sdata : 32'($urandom),
                resp && s_req[REQ_W-1] && (wseen == lat)};
    end
    chk({name, "_ready_cycle"}, 128'(ready_at), 128'(waitc + 1));
    chk({name, "_rdata"}, 128'(got_rd), 128'(exp_rd));
    chk({name, "_err"}, 128'(got_err), 128'(exp_err));
    step();
    if (busy) busyc++;
    chk({name, "_resp_after"}, 128'(m_resp), 128'(0));
    chk({name, "_err_after"}, 128'(timeout_err), 128'(0));
    chk({name, "_svalid_cycles"}, 128'(svc), 128'(waitc));
    chk({name, "_busy_cycles"}, 128'(busyc), 128'(waitc + 1));
    chk({name, "_err_pulses"}, 128'(errc), 128'(exp_err));
  endtask

  initial begin
    rst_n  = 1'b0;
    m_req  = '0;
    s_resp = '0;
    #1;
    chk("rst_sreq", 128'(s_req), 128'(0));
    chk("rst_mresp", 128'(m_resp), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_err", 128'(timeout_err), 128'(0));
    step();
    step();
    rst_n = 1'b1;
    step();

    run_txn("t1_read", 32'h0000_0010, 32'h0, 4'h0, 1, 1'b1, 32'h1234_5678);
    run_txn("t2_write", 32'h0000_0040, 32'hA5A5_A5A5, 4'hF, 5, 1'b1, 32'h0BAD_F00D);

    run_txn("t3_abort", 32'h0000_0080, 32'h1111_2222, 4'h3, 0, 1'b0, 32'h0);
    s_resp = {32'hCAFE_F00D, 1'b1};
    step();
    s_resp = '0;
    chk("t3_spur_busy", 128'(busy), 128'(0));
    chk("t3_spur_svalid", 128'(s_req[REQ_W-1]), 128'(0));
    step();
    chk("t3_spur_resp", 128'(m_resp), 128'(0));
    chk("t3_spur_err", 128'(timeout_err), 128'(0));

    run_txn("t4_edge", 32'h0000_00C0, 32'h3333_4444, 4'hC, 8, 1'b1, 32'h5555_6666);

    // Two masters alternating through the merge; random latencies, some beyond the watchdog.
    for (int i = 0; i < 10; i++) begin
      run_txn((i % 2 == 0) ? "t5_m0" : "t5_m1", 32'($urandom), 32'($urandom),
              4'($urandom), int'($urandom_range(1, 10)), ($urandom_range(0, 3) != 0),
              32'($urandom));
    end

    m_req  = {1'b1, 32'h0000_0100, 32'h7777_8888, 4'h5};
    s_resp = '0;
    step();
    step();
    chk("t6_pre_busy", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #2;
    chk("t6_svalid", 128'(s_req[REQ_W-1]), 128'(0));
    chk("t6_busy", 128'(busy), 128'(0));
    chk("t6_resp", 128'(m_resp), 128'(0));
    step();
    step();
    rst_n = 1'b1;
    run_txn("t6_restart", 32'h0000_0104, 32'h9999_AAAA, 4'hA, 2, 1'b1, 32'h1357_9BDF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
